// File: rtl/riscv_lsu.sv
// Load/store unit between the core execute stage and a word-wide data memory.
// One access in flight at a time. Variable-latency memory uses a req/ack handshake.
module riscv_lsu #(
  parameter int data_width_p = 32,
  parameter int addr_p       = 10,
  parameter int byte_addr_p  = addr_p + $clog2(data_width_p/8)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_we_i,
  input  logic [1:0]                req_size_i,
  input  logic                      req_unsigned_i,
  input  logic [byte_addr_p-1:0]    req_addr_i,
  input  logic [data_width_p-1:0]   req_wdata_i,
  output logic                      resp_valid_o,
  output logic [data_width_p-1:0]   resp_rdata_o,
  output logic                      resp_err_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [addr_p-1:0]         mem_addr_o,
  output logic [data_width_p/8-1:0] mem_be_o,
  output logic [data_width_p-1:0]   mem_wdata_o,
  input  logic                      mem_ack_i,
  input  logic [data_width_p-1:0]   mem_rdata_i
);

  localparam int BYTES = data_width_p / 8;
  localparam int OFF_W = $clog2(BYTES);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t           state;
  logic [1:0]       lat_size;
  logic             lat_unsigned;
  logic [OFF_W-1:0] lat_off;
  logic [OFF_W-1:0] req_off;

  assign req_off = req_addr_i[OFF_W-1:0];

  // Wider than the data path, or not naturally aligned to its own size.
  function automatic logic access_illegal(input logic [1:0] size, input logic [OFF_W-1:0] off);
    int nb;
    nb = 1 << size;
    return (nb > BYTES) || ((int'(off) & (nb - 1)) != 0);
  endfunction

  function automatic logic [BYTES-1:0] lane_be(input logic [1:0] size, input logic [OFF_W-1:0] off);
    logic [BYTES-1:0] m;
    m = ~({BYTES{1'b1}} << (1 << size));
    return m << off;
  endfunction

  function automatic logic [data_width_p-1:0] lane_wdata(input logic [data_width_p-1:0] wdata,
                                                         input logic [1:0] size,
                                                         input logic [OFF_W-1:0] off);
    logic [data_width_p-1:0] m;
    m = ~({data_width_p{1'b1}} << (8 << size));
    return (wdata & m) << {off, 3'b000};
  endfunction

  // Right-justify the addressed field, then zero- or sign-extend it to full width.
  function automatic logic [data_width_p-1:0] load_extend(input logic [data_width_p-1:0] word,
                                                          input logic [1:0] size,
                                                          input logic [OFF_W-1:0] off,
                                                          input logic uns);
    logic [data_width_p-1:0] shifted;
    logic [data_width_p-1:0] mask;
    logic [data_width_p-1:0] top;
    logic                    ext;
    int                      nbits;
    shifted = word >> {off, 3'b000};
    nbits   = 8 << size;
    mask    = ~({data_width_p{1'b1}} << nbits);
    top     = shifted >> (nbits - 1);
    ext     = ~uns & top[0];
    return (shifted & mask) | ({data_width_p{ext}} & ~mask);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      req_ready_o  <= 1'b1;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_be_o     <= '0;
      mem_wdata_o  <= '0;
      resp_valid_o <= 1'b0;
      resp_err_o   <= 1'b0;
      resp_rdata_o <= '0;
      lat_size     <= '0;
      lat_unsigned <= 1'b0;
      lat_off      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            req_ready_o  <= 1'b0;
            lat_size     <= req_size_i;
            lat_unsigned <= req_unsigned_i;
            lat_off      <= req_off;
            if (access_illegal(req_size_i, req_off)) begin
              state        <= RESP;
              resp_valid_o <= 1'b1;
              resp_err_o   <= 1'b1;
              resp_rdata_o <= '0;
            end else begin
              state       <= ISSUE;
              mem_req_o   <= 1'b1;
              mem_we_o    <= req_we_i;
              mem_addr_o  <= req_addr_i[byte_addr_p-1:OFF_W];
              mem_be_o    <= lane_be(req_size_i, req_off);
              mem_wdata_o <= lane_wdata(req_wdata_i, req_size_i, req_off);
            end
          end
        end
        ISSUE: begin
          if (mem_ack_i) begin
            state        <= RESP;
            mem_req_o    <= 1'b0;
            resp_valid_o <= 1'b1;
            resp_err_o   <= 1'b0;
            resp_rdata_o <= mem_we_o ? '0
                          : load_extend(mem_rdata_i, lat_size, lat_off, lat_unsigned);
          end
        end
        RESP: begin
          state        <= IDLE;
          resp_valid_o <= 1'b0;
          req_ready_o  <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu at 32-bit data width and 10-bit word address.
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  riscv_lsu #(.data_width_p(32), .addr_p(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [11:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
  endtask

  task automatic txn(input string tag, input logic we, input logic [1:0] size, input logic uns,
                     input logic [11:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                     input int delay, input logic [9:0] e_addr, input logic [3:0] e_be,
                     input logic [31:0] e_wdata, input logic [31:0] e_rdata);
    check({tag, ":ready_idle"}, req_ready, 1);
    drive_req(we, size, uns, addr, wdata);
    step();
    req_valid = 1'b0;
    req_addr  = 12'hFFF;
    req_wdata = 32'hDEADDEAD;
    check({tag, ":mem_req"}, mem_req, 1);
    check({tag, ":mem_we"}, mem_we, we);
    check({tag, ":mem_addr"}, mem_addr, e_addr);
    check({tag, ":mem_be"}, mem_be, e_be);
    check({tag, ":mem_wdata"}, mem_wdata, e_wdata);
    check({tag, ":ready_busy"}, req_ready, 0);
    for (int i = 0; i < delay; i++) begin
      step();
      check({tag, ":req_held"}, mem_req, 1);
      check({tag, ":be_held"}, mem_be, e_be);
      check({tag, ":no_resp"}, resp_valid, 0);
    end
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    step();
    mem_ack   = 1'b0;
    mem_rdata = 32'h5A5A5A5A;
    check({tag, ":resp_valid"}, resp_valid, 1);
    check({tag, ":resp_err"}, resp_err, 0);
    check({tag, ":resp_rdata"}, resp_rdata, e_rdata);
    check({tag, ":mem_req_drop"}, mem_req, 0);
    step();
    check({tag, ":resp_pulse"}, resp_valid, 0);
    check({tag, ":ready_back"}, req_ready, 1);
  endtask

  task automatic err_txn(input string tag, input logic [1:0] size, input logic [11:0] addr);
    check({tag, ":ready_idle"}, req_ready, 1);
    drive_req(1'b0, size, 1'b0, addr, 32'h0);
    step();
    req_valid = 1'b0;
    check({tag, ":resp_valid"}, resp_valid, 1);
    check({tag, ":resp_err"}, resp_err, 1);
    check({tag, ":resp_rdata"}, resp_rdata, 0);
    check({tag, ":no_mem_req"}, mem_req, 0);
    step();
    check({tag, ":resp_pulse"}, resp_valid, 0);
    check({tag, ":no_mem_req2"}, mem_req, 0);
    check({tag, ":ready_back"}, req_ready, 1);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0; mem_ack = 0; mem_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst:ready", req_ready, 1);
    check("rst:mem_req", mem_req, 0);
    check("rst:mem_we", mem_we, 0);
    check("rst:resp_valid", resp_valid, 0);
    check("rst:resp_err", resp_err, 0);
    check("rst:mem_addr", mem_addr, 0);
    check("rst:mem_be", mem_be, 0);
    check("rst:mem_wdata", mem_wdata, 0);
    check("rst:resp_rdata", resp_rdata, 0);
    rst = 1'b0;
    step();

    txn("sb", 1, 2'd0, 0, 12'h007, 32'h000000A5, 32'h0, 2, 10'h001, 4'b1000, 32'hA5000000, 32'h0);
    txn("lbu", 0, 2'd0, 1, 12'h006, 32'h0, 32'h12F45678, 1, 10'h001, 4'b0100, 32'h0, 32'h000000F4);
    txn("lb", 0, 2'd0, 0, 12'h006, 32'h0, 32'h12F45678, 0, 10'h001, 4'b0100, 32'h0, 32'hFFFFFFF4);
    txn("lh", 0, 2'd1, 0, 12'h002, 32'h0, 32'h80011234, 1, 10'h000, 4'b1100, 32'h0, 32'hFFFF8001);
    txn("lhu", 0, 2'd1, 1, 12'h002, 32'h0, 32'h80011234, 0, 10'h000, 4'b1100, 32'h0, 32'h00008001);
    txn("sh", 1, 2'd1, 0, 12'h000, 32'hFFFF1234, 32'h0, 0, 10'h000, 4'b0011, 32'h00001234, 32'h0);
    txn("lw", 0, 2'd2, 0, 12'h3FC, 32'h0, 32'hDEADBEEF, 1, 10'h0FF, 4'b1111, 32'h0, 32'hDEADBEEF);
    txn("lb_pos", 0, 2'd0, 0, 12'h003, 32'h0, 32'h7F000000, 0, 10'h000, 4'b1000, 32'h0, 32'h0000007F);

    err_txn("lw_mis", 2'd2, 12'h005);
    err_txn("lh_mis", 2'd1, 12'h003);
    err_txn("ld_w32", 2'd3, 12'h000);

    // Back-to-back loads, ack in the first ISSUE cycle, second request held pending.
    drive_req(1'b0, 2'd2, 1'b0, 12'h000, 32'h0);
    step();
    check("b2b:mem_req1", mem_req, 1);
    check("b2b:addr1", mem_addr, 10'h000);
    mem_ack = 1'b1;
    mem_rdata = 32'h11223344;
    drive_req(1'b0, 2'd2, 1'b0, 12'h008, 32'h0);
    step();
    mem_ack = 1'b0;
    check("b2b:resp1", resp_valid, 1);
    check("b2b:rdata1", resp_rdata, 32'h11223344);
    check("b2b:ready_k2", req_ready, 0);
    step();
    check("b2b:ready_k3", req_ready, 1);
    check("b2b:resp_off_k3", resp_valid, 0);
    check("b2b:mem_req_k3", mem_req, 0);
    step();
    req_valid = 1'b0;
    check("b2b:mem_req2", mem_req, 1);
    check("b2b:addr2", mem_addr, 10'h002);
    check("b2b:ready_k4", req_ready, 0);
    mem_ack = 1'b1;
    mem_rdata = 32'h55667788;
    step();
    mem_ack = 1'b0;
    check("b2b:resp2", resp_valid, 1);
    check("b2b:rdata2", resp_rdata, 32'h55667788);
    step();

    // Ack while idle must not create a response.
    mem_ack = 1'b1;
    step();
    check("idle_ack:no_resp", resp_valid, 0);
    check("idle_ack:no_req", mem_req, 0);
    mem_ack = 1'b0;

    // Async reset mid-ISSUE abandons the access.
    drive_req(1'b0, 2'd2, 1'b0, 12'h00C, 32'h0);
    step();
    req_valid = 1'b0;
    check("rst_mid:mem_req", mem_req, 1);
    check("rst_mid:addr", mem_addr, 10'h003);
    #2 rst = 1'b1;
    #1;
    check("rst_mid:req_drop", mem_req, 0);
    check("rst_mid:ready", req_ready, 1);
    check("rst_mid:addr_clr", mem_addr, 0);
    check("rst_mid:no_resp", resp_valid, 0);
    step();
    rst = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    step();
    check("late_ack:no_resp1", resp_valid, 0);
    check("late_ack:no_req1", mem_req, 0);
    step();
    check("late_ack:no_resp2", resp_valid, 0);
    check("late_ack:ready", req_ready, 1);
    mem_ack = 1'b0;
    step();

    txn("after_rst", 0, 2'd0, 1, 12'h001, 32'h0, 32'h0000AB00, 0, 10'h000, 4'b0010, 32'h0, 32'h000000AB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
